// File: rtl/ascon_ti_pkg.sv
// Shared definitions for the 3-share threshold-implementation Ascon round datapath:
// word geometry, FSM encoding, diffusion rotation amounts and the round constant.
package ascon_ti_pkg;

    localparam int ASCON_W      = 64;
    localparam int STATE_W      = 5 * ASCON_W;
    localparam int ASCON_ROUNDS = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int ROT_X0_A = 19;
    localparam int ROT_X0_B = 28;
    localparam int ROT_X1_A = 61;
    localparam int ROT_X1_B = 39;
    localparam int ROT_X2_A = 1;
    localparam int ROT_X2_B = 6;
    localparam int ROT_X3_A = 10;
    localparam int ROT_X3_B = 17;
    localparam int ROT_X4_A = 7;
    localparam int ROT_X4_B = 41;

    // c(i): upper nibble counts down from 15 while the lower nibble counts up
    function automatic logic [7:0] round_const(input logic [3:0] idx);
        round_const = {4'hF - idx, idx};
    endfunction

    function automatic logic [ASCON_W-1:0] rotr(input logic [ASCON_W-1:0] w, input int amt);
        rotr = (w >> amt) | (w << (ASCON_W - amt));
    endfunction

    function automatic logic [ASCON_W-1:0] diffuse(input logic [ASCON_W-1:0] w,
                                                   input int a, input int b);
        diffuse = w ^ rotr(w, a) ^ rotr(w, b);
    endfunction

endpackage

// File: rtl/ascon_ti_linear.sv
// Ascon linear diffusion layer for a single share; linear, so it is applied to
// each share independently without touching the masking.
module ascon_ti_linear
    import ascon_ti_pkg::*;
(
    input  logic [STATE_W-1:0] x,
    output logic [STATE_W-1:0] y
);

    logic [ASCON_W-1:0] x0_s, x1_s, x2_s, x3_s, x4_s;

    assign {x0_s, x1_s, x2_s, x3_s, x4_s} = x;

    assign y = {diffuse(x0_s, ROT_X0_A, ROT_X0_B),
                diffuse(x1_s, ROT_X1_A, ROT_X1_B),
                diffuse(x2_s, ROT_X2_A, ROT_X2_B),
                diffuse(x3_s, ROT_X3_A, ROT_X3_B),
                diffuse(x4_s, ROT_X4_A, ROT_X4_B)};

endmodule

// File: rtl/ascon_ti_round_ctrl.sv
// Sequential round stage around an external 3-share TI Ascon S-box layer: holds the
// shared state, adds the round constant to share 0, re-masks and diffuses each round.
module ascon_ti_round_ctrl
    import ascon_ti_pkg::*;
#(
    parameter int ROUNDS_MAX = ASCON_ROUNDS,
    parameter int W          = ASCON_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_rounds,
    input  logic [5*W-1:0]    in_s0,
    input  logic [5*W-1:0]    in_s1,
    input  logic [5*W-1:0]    in_s2,
    input  logic [10*W-1:0]   rnd,
    input  logic              rnd_valid,
    output logic [5*W-1:0]    sb_in_s0,
    output logic [5*W-1:0]    sb_in_s1,
    output logic [5*W-1:0]    sb_in_s2,
    input  logic [5*W-1:0]    sb_out_s0,
    input  logic [5*W-1:0]    sb_out_s1,
    input  logic [5*W-1:0]    sb_out_s2,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5*W-1:0]    out_s0,
    output logic [5*W-1:0]    out_s1,
    output logic [5*W-1:0]    out_s2
);

    localparam logic [3:0] RMAX = 4'(ROUNDS_MAX);

    state_e             state_r, state_nxt_s;
    logic [3:0]         idx_r, last_r;
    logic [5*W-1:0]     share0_r, share1_r, share2_r;
    logic [5*W-1:0]     rc_mask_s;
    logic [5*W-1:0]     r0_s, r1_s;
    logic [5*W-1:0]     t0_s, t1_s, t2_s;
    logic [5*W-1:0]     lin0_s, lin1_s, lin2_s;
    logic [3:0]         eff_rounds_s;
    logic               load_s, round_s;

    assign eff_rounds_s = ((in_rounds == 4'd0) || (in_rounds > RMAX)) ? RMAX : in_rounds;

    // Place c(idx) in the low byte of word x2 of share 0 only
    always_comb begin
        rc_mask_s = '0;
        rc_mask_s[2*W +: 8] = round_const(idx_r);
    end

    assign sb_in_s0 = share0_r ^ rc_mask_s;
    assign sb_in_s1 = share1_r;
    assign sb_in_s2 = share2_r;

    // Fresh randomness cancels across the three shares, so the shared value is unchanged
    assign r0_s = rnd[10*W-1:5*W];
    assign r1_s = rnd[5*W-1:0];
    assign t0_s = sb_out_s0 ^ r0_s;
    assign t1_s = sb_out_s1 ^ r1_s;
    assign t2_s = sb_out_s2 ^ r0_s ^ r1_s;

    ascon_ti_linear u_lin0 (.x(t0_s), .y(lin0_s));
    ascon_ti_linear u_lin1 (.x(t1_s), .y(lin1_s));
    ascon_ti_linear u_lin2 (.x(t2_s), .y(lin2_s));

    // Next-state logic and load/round strobes
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        round_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = ST_RUN;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (rnd_valid) begin
                    round_s = 1'b1;
                    if (idx_r == last_r) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, round index and the three state shares; a stalled round updates nothing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            idx_r    <= 4'd0;
            last_r   <= 4'd0;
            share0_r <= '0;
            share1_r <= '0;
            share2_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (load_s) begin
                share0_r <= in_s0;
                share1_r <= in_s1;
                share2_r <= in_s2;
                idx_r    <= RMAX - eff_rounds_s;
                last_r   <= RMAX - 4'd1;
            end else if (round_s) begin
                share0_r <= lin0_s;
                share1_r <= lin1_s;
                share2_r <= lin2_s;
                if (idx_r != last_r) begin
                    idx_r <= idx_r + 4'd1;
                end
            end
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign busy      = (state_r == ST_RUN);
    assign out_valid = (state_r == ST_DONE);
    assign out_s0    = share0_r;
    assign out_s1    = share1_r;
    assign out_s2    = share2_r;

endmodule

// File: tb/tb_ascon_ti_round_ctrl.sv
// Directed, table-driven bench for ascon_ti_round_ctrl against an unmasked Ascon
// permutation model; a behavioural share-preserving stand-in plays the S-box layer.
module tb_ascon_ti_round_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   in_rounds = 4'd0;
    logic [319:0] in_s0 = '0, in_s1 = '0, in_s2 = '0;
    logic [639:0] rnd = '0;
    logic         rnd_valid = 1'b0;
    logic [319:0] sb_in_s0, sb_in_s1, sb_in_s2;
    logic [319:0] sb_out_s0, sb_out_s1, sb_out_s2;
    logic         busy, out_valid;
    logic         out_ready = 1'b0;
    logic [319:0] out_s0, out_s1, out_s2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ascon_ti_round_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rounds(in_rounds), .in_s0(in_s0), .in_s1(in_s1), .in_s2(in_s2),
        .rnd(rnd), .rnd_valid(rnd_valid),
        .sb_in_s0(sb_in_s0), .sb_in_s1(sb_in_s1), .sb_in_s2(sb_in_s2),
        .sb_out_s0(sb_out_s0), .sb_out_s1(sb_out_s1), .sb_out_s2(sb_out_s2),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_s0(out_s0), .out_s1(out_s1), .out_s2(out_s2)
    );

    function automatic logic [319:0] ref_sbox(input logic [319:0] s);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic logic [63:0] ref_rot(input logic [63:0] w, input int a);
        logic [63:0] o;
        for (int j = 0; j < 64; j++) o[j] = w[(j + a) % 64];
        return o;
    endfunction

    function automatic logic [319:0] ref_lin(input logic [319:0] s);
        logic [63:0] x0, x1, x2, x3, x4;
        {x0, x1, x2, x3, x4} = s;
        x0 = x0 ^ ref_rot(x0, 19) ^ ref_rot(x0, 28);
        x1 = x1 ^ ref_rot(x1, 61) ^ ref_rot(x1, 39);
        x2 = x2 ^ ref_rot(x2, 1)  ^ ref_rot(x2, 6);
        x3 = x3 ^ ref_rot(x3, 10) ^ ref_rot(x3, 17);
        x4 = x4 ^ ref_rot(x4, 7)  ^ ref_rot(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int r);
        logic [319:0] st;
        logic [7:0]   rc;
        st = s;
        for (int i = 12 - r; i < 12; i++) begin
            rc = 8'((15 - i) * 16 + i);
            st[135:128] = st[135:128] ^ rc;
            st = ref_lin(ref_sbox(st));
        end
        return st;
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int k = 0; k < 10; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Stand-in S-box layer: correct on the shared value, shares 1 and 2 pass through
    always_comb begin
        sb_out_s1 = sb_in_s1;
        sb_out_s2 = sb_in_s2;
        sb_out_s0 = ref_sbox(sb_in_s0 ^ sb_in_s1 ^ sb_in_s2) ^ sb_in_s1 ^ sb_in_s2;
    end

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Load, run to DONE (optionally with random stalls), then acknowledge the result
    task automatic run_op(input logic [3:0] rounds, input logic [319:0] a0, a1, a2,
                          input bit stall, input bit zero_rnd,
                          output logic [319:0] res, output int lat, output int busy_n,
                          output int stalls, output logic [7:0] rc_first, output int hold_err);
        logic [959:0] prev;
        in_rounds = rounds; in_s0 = a0; in_s1 = a1; in_s2 = a2;
        in_valid = 1'b1; rnd_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rc_first = sb_in_s0[135:128] ^ a0[135:128];
        lat = 1; busy_n = 0; stalls = 0; hold_err = 0;
        while (!out_valid && lat < 200) begin
            if (busy) busy_n++;
            rnd = zero_rnd ? 640'd0 : {rand320(), rand320()};
            rnd_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!rnd_valid) stalls++;
            prev = {out_s0, out_s1, out_s2};
            @(posedge clk); #1;
            lat++;
            if (!rnd_valid && ({out_s0, out_s1, out_s2} != prev)) hold_err++;
        end
        res = out_s0 ^ out_s1 ^ out_s2;
        rnd_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [3:0] rounds;
        bit         use_iv;
        bit         stall;
        int         exp_rounds;
        logic [7:0] exp_rc;
    } vec_t;

    vec_t vecs[7];

    logic [319:0] iv_state, zero_state, a0, a1, a2, res, hold_v;
    logic [7:0]   rc;
    int           lat, busy_n, stalls, hold_err, n;

    initial begin
        iv_state   = {64'h80400c0600000000, 64'h0011223344556677, 64'h8899aabbccddeeff,
                      64'h0001020304050607, 64'h08090a0b0c0d0e0f};
        zero_state = '0;
        vecs[0] = '{4'd12, 1'b0, 1'b0, 12, 8'hF0};
        vecs[1] = '{4'd6,  1'b1, 1'b0, 6,  8'h96};
        vecs[2] = '{4'd8,  1'b1, 1'b0, 8,  8'hB4};
        vecs[3] = '{4'd6,  1'b1, 1'b1, 6,  8'h96};
        vecs[4] = '{4'd0,  1'b1, 1'b0, 12, 8'hF0};
        vecs[5] = '{4'd15, 1'b1, 1'b0, 12, 8'hF0};
        vecs[6] = '{4'd1,  1'b1, 1'b0, 1,  8'h4B};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_s", out_s0 | out_s1 | out_s2, 320'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].use_iv) begin
                a1 = rand320(); a2 = rand320(); a0 = iv_state ^ a1 ^ a2;
            end else begin
                a0 = zero_state; a1 = zero_state; a2 = zero_state;
            end
            run_op(vecs[v].rounds, a0, a1, a2, vecs[v].stall, !vecs[v].use_iv,
                   res, lat, busy_n, stalls, rc, hold_err);
            chk($sformatf("v%0d_first_rc", v), rc, vecs[v].exp_rc);
            chk($sformatf("v%0d_result", v), res,
                ref_perm(vecs[v].use_iv ? iv_state : zero_state, vecs[v].exp_rounds));
            chk($sformatf("v%0d_latency", v), lat, vecs[v].exp_rounds + stalls + 1);
            chk($sformatf("v%0d_busy_cycles", v), busy_n, vecs[v].exp_rounds + stalls);
            chk($sformatf("v%0d_stall_hold", v), hold_err, 0);
        end

        // DONE held with in_valid asserted; then IDLE, then a new load
        a1 = rand320(); a2 = rand320(); a0 = iv_state ^ a1 ^ a2;
        in_rounds = 4'd1; in_s0 = a0; in_s1 = a1; in_s2 = a2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; rnd = {rand320(), rand320()}; rnd_valid = 1'b1;
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("done_reached", out_valid, 1'b1);
        rnd_valid = 1'b0;
        hold_v = out_s0 ^ out_s1 ^ out_s2;
        chk("done_result", hold_v, ref_perm(iv_state, 1));
        a1 = rand320(); a2 = rand320(); a0 = zero_state ^ a1 ^ a2;
        in_rounds = 4'd2; in_s0 = a0; in_s1 = a1; in_s2 = a2; in_valid = 1'b1;
        hold_v = out_s0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("done_hold_out_s0", out_s0, hold_v);
            chk("done_hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("ack_idle_in_ready", in_ready, 1'b1);
        chk("ack_idle_busy", busy, 1'b0);
        chk("ack_idle_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("reload_busy", busy, 1'b1);
        rnd_valid = 1'b1;
        n = 0;
        while (!out_valid && n < 50) begin
            rnd = {rand320(), rand320()};
            @(posedge clk); #1; n++;
        end
        chk("reload_rounds", n, 2);
        chk("reload_result", out_s0 ^ out_s1 ^ out_s2, ref_perm(zero_state, 2));
        rnd_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Asynchronous reset after three of twelve rounds
        a1 = rand320(); a2 = rand320(); a0 = iv_state ^ a1 ^ a2;
        in_rounds = 4'd12; in_s0 = a0; in_s1 = a1; in_s2 = a2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; rnd_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            rnd = {rand320(), rand320()};
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_s", out_s0 | out_s1 | out_s2, 320'd0);
        rnd_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("postrst_out_valid", out_valid, 1'b0);
        a1 = rand320(); a2 = rand320(); a0 = iv_state ^ a1 ^ a2;
        run_op(4'd12, a0, a1, a2, 1'b0, 1'b0, res, lat, busy_n, stalls, rc, hold_err);
        chk("postrst_result", res, ref_perm(iv_state, 12));
        chk("postrst_latency", lat, 13);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
